// File: rtl/pkg_instr_dec.sv
// Shared decode definitions for the SPARK80 prefetch path: FSM states, group-5 mark, length helper.
// ST_INT exists only when SPARK80_PREFETCH_INT_EN is defined.
package pkg_instr_dec;

   localparam int unsigned HW_WIDTH  = 16;
   localparam logic [2:0]  GRP5_MARK = 3'b111;

   typedef enum logic [1:0] {
      ST_VEC = 2'd0,
      ST_RUN = 2'd1
`ifdef SPARK80_PREFETCH_INT_EN
      , ST_INT = 2'd2
`endif
   } pf_state_e;

   // Halfword count of the instruction that starts with this halfword.
   function automatic logic [1:0] instr_hw_len(input logic [HW_WIDTH-1:0] hw);
      return (hw[15:13] == GRP5_MARK) ? 2'd2 : 2'd1;
   endfunction

endpackage

// File: rtl/spark80_hw_queue.sv
// Power-of-two halfword FIFO with single push, one/two-entry pop and flush.
module spark80_hw_queue
   import pkg_instr_dec::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                push,
   input  logic [HW_WIDTH-1:0] push_data,
   input  logic                pop1,
   input  logic                pop2,
   output logic [CNT_W-1:0]    count,
   output logic [HW_WIDTH-1:0] head,
   output logic [HW_WIDTH-1:0] next_hw
);

   logic [HW_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    wr_ptr;
   logic                push_ok;
   logic [1:0]          pop_n;

   assign push_ok = push && (count < CNT_W'(DEPTH));

   // Pops are clamped to the entries actually present.
   always_comb begin
      pop_n = 2'd0;
      if (pop2 && (count >= CNT_W'(2)))
         pop_n = 2'd2;
      else if (pop1 && (count >= CNT_W'(1)))
         pop_n = 2'd1;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr <= rd_ptr + PTR_W'(pop_n);
         count  <= count + CNT_W'(push_ok) - CNT_W'(pop_n);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++)
            mem[i] <= '0;
      end else if (push_ok && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign head    = mem[rd_ptr];
   assign next_hw = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/spark80_prefetch_unit.sv
// SPARK80 instruction prefetch: vector fetch, halfword streaming into a queue, 16/32-bit assembly.
// Optional interrupt vectoring enabled by defining SPARK80_PREFETCH_INT_EN.
module spark80_prefetch_unit
   import pkg_instr_dec::*;
#(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_VEC_ADDR = '0,
   parameter logic [ADDR_WIDTH-1:0] INT_VEC_ADDR = ADDR_WIDTH'(2)
)(
   input  logic                  clk,
   input  logic                  reset,
   output logic                  bus_req,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   input  logic                  bus_ready,
   input  logic [15:0]           bus_data_in,
   output logic                  instr_valid,
   output logic [31:0]           instr_out,
   output logic                  instr_is_32,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  instr_take,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_addr
`ifdef SPARK80_PREFETCH_INT_EN
   ,
   input  logic                  interrupt,
   input  logic                  ints_enabled,
   output logic                  int_ack,
   output logic [ADDR_WIDTH-1:0] int_ret_addr
`endif
);

   localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

   pf_state_e             state;
   pf_state_e             state_nxt;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic [CNT_W-1:0]      q_count;
   logic [HW_WIDTH-1:0]   q_head;
   logic [HW_WIDTH-1:0]   q_next;
   logic                  q_flush;
   logic                  q_push;
   logic                  q_pop1;
   logic                  q_pop2;
   logic                  q_room;
   logic                  head_is_32;
   logic                  vec_load;
   logic                  redir_load;
   logic                  fetch_adv;
   logic                  int_entry;
   logic [ADDR_WIDTH-1:0] pc_step;
   logic [ADDR_WIDTH-1:0] vec_target;
   logic [ADDR_WIDTH-1:0] redir_target;

   assign q_room       = q_count < CNT_W'(QUEUE_DEPTH);
   assign head_is_32   = instr_hw_len(q_head) == 2'd2;
   assign vec_target   = ADDR_WIDTH'(bus_data_in) & ~ADDR_WIDTH'(1);
   assign redir_target = redirect_addr & ~ADDR_WIDTH'(1);

   spark80_hw_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush     (q_flush),
      .push      (q_push),
      .push_data (bus_data_in),
      .pop1      (q_pop1),
      .pop2      (q_pop2),
      .count     (q_count),
      .head      (q_head),
      .next_hw   (q_next)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_VEC;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_VEC: if (bus_ready) state_nxt = ST_RUN;
`ifdef SPARK80_PREFETCH_INT_EN
         ST_INT: if (bus_ready) state_nxt = ST_RUN;
         ST_RUN: if (!redirect && interrupt && ints_enabled) state_nxt = ST_INT;
`endif
         default: state_nxt = state;
      endcase
   end

   // Head decode; a 32-bit head is only presented once its second half has arrived.
   always_comb begin
      instr_valid = 1'b0;
      instr_is_32 = 1'b0;
      instr_out   = '0;
      if (!reset && (q_count != '0)) begin
         instr_is_32 = head_is_32;
         instr_valid = head_is_32 ? (q_count >= CNT_W'(2)) : 1'b1;
         instr_out   = {q_head, head_is_32 ? q_next : 16'h0000};
      end
   end

   // Bus request and queue/pointer controls; redirect and interrupt entry override take.
   always_comb begin
      bus_req    = 1'b0;
      bus_addr   = '0;
      q_flush    = 1'b0;
      q_push     = 1'b0;
      q_pop1     = 1'b0;
      q_pop2     = 1'b0;
      vec_load   = 1'b0;
      redir_load = 1'b0;
      fetch_adv  = 1'b0;
      int_entry  = 1'b0;
      pc_step    = '0;
      if (!reset) begin
         case (state)
            ST_RUN: begin
               bus_req  = q_room;
               bus_addr = fetch_addr;
               if (redirect) begin
                  q_flush    = 1'b1;
                  redir_load = 1'b1;
               end
`ifdef SPARK80_PREFETCH_INT_EN
               else if (interrupt && ints_enabled) begin
                  q_flush   = 1'b1;
                  int_entry = 1'b1;
               end
`endif
               else begin
                  q_push    = q_room && bus_ready;
                  fetch_adv = q_room && bus_ready;
                  if (instr_take && instr_valid) begin
                     q_pop1  = !instr_is_32;
                     q_pop2  = instr_is_32;
                     pc_step = instr_is_32 ? ADDR_WIDTH'(4) : ADDR_WIDTH'(2);
                  end
               end
            end
`ifdef SPARK80_PREFETCH_INT_EN
            ST_INT: begin
               bus_req  = 1'b1;
               bus_addr = INT_VEC_ADDR;
               vec_load = bus_ready;
            end
`endif
            default: begin
               bus_req  = 1'b1;
               bus_addr = RESET_VEC_ADDR;
               vec_load = bus_ready;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_addr <= '0;
         instr_pc   <= '0;
      end else if (vec_load) begin
         fetch_addr <= vec_target;
         instr_pc   <= vec_target;
      end else if (redir_load) begin
         fetch_addr <= redir_target;
         instr_pc   <= redir_target;
      end else begin
         if (fetch_adv)
            fetch_addr <= fetch_addr + ADDR_WIDTH'(2);
         instr_pc <= instr_pc + pc_step;
      end
   end

`ifdef SPARK80_PREFETCH_INT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         int_ack      <= 1'b0;
         int_ret_addr <= '0;
      end else begin
         int_ack <= vec_load && (state == ST_INT);
         if (int_entry)
            int_ret_addr <= instr_pc;
      end
   end
`else
   // INT_VEC_ADDR has no consumer without the interrupt path.
   logic unused_int_vec;
   assign unused_int_vec = ^INT_VEC_ADDR;
`endif

endmodule

// File: tb/tb_spark80_prefetch_unit.sv
// Directed self-checking bench for spark80_prefetch_unit (default parameters).
module tb_spark80_prefetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        bus_req;
   logic [15:0] bus_addr;
   logic        bus_ready;
   logic [15:0] bus_data_in;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic        instr_is_32;
   logic [15:0] instr_pc;
   logic        instr_take;
   logic        redirect;
   logic [15:0] redirect_addr;
`ifdef SPARK80_PREFETCH_INT_EN
   logic        interrupt;
   logic        ints_enabled;
   logic        int_ack;
   logic [15:0] int_ret_addr;
`endif

   int n_checks = 0;
   int n_errors = 0;

   spark80_prefetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .bus_req       (bus_req),
      .bus_addr      (bus_addr),
      .bus_ready     (bus_ready),
      .bus_data_in   (bus_data_in),
      .instr_valid   (instr_valid),
      .instr_out     (instr_out),
      .instr_is_32   (instr_is_32),
      .instr_pc      (instr_pc),
      .instr_take    (instr_take),
      .redirect      (redirect),
      .redirect_addr (redirect_addr)
`ifdef SPARK80_PREFETCH_INT_EN
      ,
      .interrupt     (interrupt),
      .ints_enabled  (ints_enabled),
      .int_ack       (int_ack),
      .int_ret_addr  (int_ret_addr)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply bus/core inputs for one clock, then settle just past the edge.
   task automatic step(input logic rdy, input logic [15:0] data, input logic take);
      bus_ready   = rdy;
      bus_data_in = data;
      instr_take  = take;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; bus_ready = 1'b0; bus_data_in = '0; instr_take = 1'b0;
      redirect = 1'b0; redirect_addr = '0;
`ifdef SPARK80_PREFETCH_INT_EN
      interrupt = 1'b0; ints_enabled = 1'b0;
`endif
      step(1'b1, 16'hBEEF, 1'b1);
      step(1'b1, 16'hBEEF, 1'b1);
      check_eq("rst_bus_req", 32'(bus_req), 32'h0);
      check_eq("rst_bus_addr", 32'(bus_addr), 32'h0);
      check_eq("rst_valid", 32'(instr_valid), 32'h0);
      check_eq("rst_is32", 32'(instr_is_32), 32'h0);
      check_eq("rst_out", instr_out, 32'h0);
      check_eq("rst_pc", 32'(instr_pc), 32'h0);

      reset = 1'b0; bus_ready = 1'b0; instr_take = 1'b0;
      #1;
      check_eq("vec_req", 32'(bus_req), 32'h1);
      check_eq("vec_addr", 32'(bus_addr), 32'h0);

      step(1'b1, 16'h0100, 1'b0);
      check_eq("boot_addr", 32'(bus_addr), 32'h0100);
      check_eq("boot_pc", 32'(instr_pc), 32'h0100);
      check_eq("boot_valid", 32'(instr_valid), 32'h0);

      step(1'b1, 16'h1234, 1'b0);
      check_eq("i16_valid", 32'(instr_valid), 32'h1);
      check_eq("i16_out", instr_out, 32'h12340000);
      check_eq("i16_is32", 32'(instr_is_32), 32'h0);
      check_eq("i16_pc", 32'(instr_pc), 32'h0100);

      step(1'b1, 16'hE001, 1'b1);
      check_eq("half32_valid", 32'(instr_valid), 32'h0);
      check_eq("half32_pc", 32'(instr_pc), 32'h0102);

      step(1'b1, 16'h5678, 1'b0);
      check_eq("i32_valid", 32'(instr_valid), 32'h1);
      check_eq("i32_out", instr_out, 32'hE0015678);
      check_eq("i32_is32", 32'(instr_is_32), 32'h1);
      check_eq("i32_bus_addr", 32'(bus_addr), 32'h0106);

      step(1'b0, 16'h0000, 1'b1);
      check_eq("take32_pc", 32'(instr_pc), 32'h0106);
      check_eq("take32_valid", 32'(instr_valid), 32'h0);

      // Fill the queue with no consumer.
      step(1'b1, 16'h1111, 1'b0);
      step(1'b1, 16'h2222, 1'b0);
      step(1'b1, 16'h3333, 1'b0);
      check_eq("fill3_req", 32'(bus_req), 32'h1);
      step(1'b1, 16'h4444, 1'b0);
      check_eq("full_req", 32'(bus_req), 32'h0);
      check_eq("full_addr", 32'(bus_addr), 32'h010E);
      step(1'b1, 16'hFFFF, 1'b1);
      check_eq("drain_req", 32'(bus_req), 32'h1);
      check_eq("drain_addr", 32'(bus_addr), 32'h010E);
      check_eq("drain_pc", 32'(instr_pc), 32'h0108);
      check_eq("drain_out", instr_out, 32'h22220000);

      // Redirect with a simultaneous transfer: data dropped, new target next cycle.
      redirect = 1'b1; redirect_addr = 16'h0200;
      step(1'b1, 16'hDEAD, 1'b1);
      redirect = 1'b0;
      check_eq("redir_valid", 32'(instr_valid), 32'h0);
      check_eq("redir_addr", 32'(bus_addr), 32'h0200);
      check_eq("redir_req", 32'(bus_req), 32'h1);
      check_eq("redir_pc", 32'(instr_pc), 32'h0200);
      step(1'b1, 16'h0AAA, 1'b0);
      check_eq("redir_lat_valid", 32'(instr_valid), 32'h1);
      check_eq("redir_lat_out", instr_out, 32'h0AAA0000);

      // Address wrap with a 32-bit instruction straddling it.
      redirect = 1'b1; redirect_addr = 16'hFFFF;
      step(1'b0, 16'h0000, 1'b0);
      redirect = 1'b0;
      check_eq("wrap_addr0", 32'(bus_addr), 32'hFFFE);
      check_eq("wrap_pc0", 32'(instr_pc), 32'hFFFE);
      step(1'b1, 16'hE123, 1'b0);
      check_eq("wrap_addr1", 32'(bus_addr), 32'h0000);
      check_eq("wrap_half", 32'(instr_valid), 32'h0);
      step(1'b1, 16'h4567, 1'b0);
      check_eq("wrap_out", instr_out, 32'hE1234567);
      check_eq("wrap_is32", 32'(instr_is_32), 32'h1);
      step(1'b0, 16'h0000, 1'b1);
      check_eq("wrap_pc_adv", 32'(instr_pc), 32'h0002);
      step(1'b0, 16'h0000, 1'b1);
      check_eq("take_ignored_pc", 32'(instr_pc), 32'h0002);

`ifdef SPARK80_PREFETCH_INT_EN
      redirect = 1'b1; redirect_addr = 16'h0104;
      step(1'b0, 16'h0000, 1'b0);
      redirect = 1'b0;
      interrupt = 1'b1; ints_enabled = 1'b1;
      step(1'b1, 16'h9999, 1'b0);
      interrupt = 1'b0;
      check_eq("int_ret", 32'(int_ret_addr), 32'h0104);
      check_eq("int_vec_addr", 32'(bus_addr), 32'h0002);
      check_eq("int_ack_early", 32'(int_ack), 32'h0);
      check_eq("int_flush", 32'(instr_valid), 32'h0);
      step(1'b1, 16'h0300, 1'b0);
      check_eq("int_ack_pulse", 32'(int_ack), 32'h1);
      check_eq("int_fetch", 32'(bus_addr), 32'h0300);
      check_eq("int_pc", 32'(instr_pc), 32'h0300);
      step(1'b0, 16'h0000, 1'b0);
      check_eq("int_ack_end", 32'(int_ack), 32'h0);
`endif

      // Reset while a transfer is offered, then redirect ignored in ST_VEC.
      reset = 1'b1;
      step(1'b1, 16'h7777, 1'b0);
      check_eq("rst2_req", 32'(bus_req), 32'h0);
      check_eq("rst2_valid", 32'(instr_valid), 32'h0);
      reset = 1'b0;
      redirect = 1'b1; redirect_addr = 16'h0400;
      step(1'b0, 16'h0000, 1'b0);
      redirect = 1'b0;
      check_eq("vec_redir_addr", 32'(bus_addr), 32'h0000);
      check_eq("vec_redir_req", 32'(bus_req), 32'h1);
      step(1'b1, 16'h0500, 1'b0);
      check_eq("reboot_addr", 32'(bus_addr), 32'h0500);
      check_eq("reboot_pc", 32'(instr_pc), 32'h0500);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
